// File: rtl/mem_arbiter_if.sv
// Bus bundle around mem_arbiter: two requester ports (m0 = CPU data port,
// m1 = loader/debug port), the shared single-port memory port and the
// arbiter status outputs.
//   slave  : the arbiter's view (takes requests, drives ready/rdata/mem_*)
//   master : the surrounding system's view (drives requests, mem_rdata)
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ready;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ready;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              grant;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ready, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ready, m1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, grant
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ready, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ready, m1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a shared single-port data memory.
// One access at a time: an IDLE cycle picks a winner and latches its
// operands, then BUSY runs for WAIT_CYCLES+1 cycles; the last BUSY cycle
// strobes mem_we (writes), pulses the winner's ready and captures mem_rdata
// into the winner's rdata register (reads).
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_arbiter_if.slave (requester ports, memory port, busy/grant)
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              prio_q, prio_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic any_req;
  logic winner;
  logic done;

  assign any_req = bus.m0_req | bus.m1_req;
  // Contention is settled by the round-robin pointer; a lone requester wins outright.
  assign winner  = (bus.m0_req & bus.m1_req) ? prio_q : bus.m1_req;
  // Final BUSY cycle of an access.
  assign done    = (state_q == StBusy) && (cnt_q == 4'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prio_d   = prio_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d = winner;
          we_d    = winner ? bus.m1_we    : bus.m0_we;
          addr_d  = winner ? bus.m1_addr  : bus.m0_addr;
          wdata_d = winner ? bus.m1_wdata : bus.m0_wdata;
          cnt_d   = WaitInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StIdle;
          prio_d  = ~grant_q;
          if (!we_q) begin
            if (grant_q) rdata1_d = bus.mem_rdata;
            else         rdata0_d = bus.mem_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      prio_q   <= 1'b0;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prio_q   <= prio_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.m0_ready  = done & ~grant_q;
  assign bus.m1_ready  = done &  grant_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.mem_we    = done & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q == StBusy);
  assign bus.grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a WAIT_CYCLES=1 instance (directed table, corner
// sequences, randomized traffic against a timeline model) and a
// WAIT_CYCLES=0 instance (back-to-back write/read).
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int W1 = 1;
  localparam int RandCycles = 1500;

  logic clk = 1'b0;
  logic reset;
  logic pl_all;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();

  mem_arbiter #(.WAIT_CYCLES(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));
  mem_arbiter #(.WAIT_CYCLES(0), .ADDR_W(AW), .DATA_W(DW)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave));

  // Word-addressed memories, 64 words each, combinational read.
  logic [DW-1:0] mem1 [64];
  logic [DW-1:0] mem0 [64];

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 16) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));
  endfunction

  always @(posedge clk) begin
    if (pl_all) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= init_word(i);
        mem0[i] <= init_word(i);
      end
    end else begin
      if (b1.mem_we) mem1[b1.mem_addr[7:2]] <= b1.mem_wdata;
      if (b0.mem_we) mem0[b0.mem_addr[7:2]] <= b0.mem_wdata;
    end
  end
  assign b1.mem_rdata = mem1[b1.mem_addr[7:2]];
  assign b0.mem_rdata = mem0[b0.mem_addr[7:2]];

  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    b1.m0_req = 0; b1.m0_we = 0; b1.m0_addr = '0; b1.m0_wdata = '0;
    b1.m1_req = 0; b1.m1_we = 0; b1.m1_addr = '0; b1.m1_wdata = '0;
    b0.m0_req = 0; b0.m0_we = 0; b0.m0_addr = '0; b0.m0_wdata = '0;
    b0.m1_req = 0; b0.m1_we = 0; b0.m1_addr = '0; b0.m1_wdata = '0;
  endtask

  task automatic drive1(input bit port, input bit req, input bit we,
                        input logic [31:0] a, input logic [31:0] d);
    if (port) begin
      b1.m1_req = req; b1.m1_we = we; b1.m1_addr = a; b1.m1_wdata = d;
    end else begin
      b1.m0_req = req; b1.m0_we = we; b1.m0_addr = a; b1.m0_wdata = d;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #3;
    reset = 1'b0; pl_all = 1'b1;
    repeat (2) @(posedge clk);
    #3; pl_all = 1'b0; reset = 1'b1;
  endtask

  // One access on dut1; requester drops req on the edge where ready is sampled.
  task automatic access1(input bit port, input bit we, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int nwe,
                         output logic [31:0] waddr, output logic [31:0] wdat,
                         output int nother, output int width);
    lat = -1; nwe = 0; nother = 0; width = 0; waddr = '0; wdat = '0;
    @(posedge clk); #1;
    drive1(port, 1'b1, we, a, d);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (b1.mem_we) begin nwe++; waddr = b1.mem_addr; wdat = b1.mem_wdata; end
      if (port ? b1.m0_ready : b1.m1_ready) nother++;
      if (port ? b1.m1_ready : b1.m0_ready) begin
        if (lat < 0) lat = k;
        width++;
      end
      if (lat >= 0 && k == lat) begin
        @(posedge clk); #1;
        drive1(port, 1'b0, 1'b0, '0, '0);
      end
      if (lat >= 0 && k >= lat + 2) break;
    end
    drive1(port, 1'b0, 1'b0, '0, '0);
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_nwe;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
  } vec_t;
  vec_t vecs [5];

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          start;
    int          fin;
  } acc_t;

  // Random-phase model and requester state.
  logic [31:0] ref_mem [64];
  acc_t        acc;
  bit          have_acc, rr, lgrant, in_acc, e_we, winner, owned;
  bit          e_rdy [2];
  bit          rdy_prev [2];
  logic [31:0] laddr, lwdata;
  logic [31:0] erd [2];
  bit          rq [2];
  bit          rwe [2];
  logic [31:0] ra [2];
  logic [31:0] rd [2];

  task automatic new_ops(input int p);
    rwe[p] = 1'($urandom_range(1));
    ra[p]  = {24'h0, 6'($urandom_range(63)), 2'b00};
    rd[p]  = $urandom;
  endtask

  int lat, nwe, nother, width, kfirst;
  logic [31:0] waddr, wdat;
  int rdy_cyc [$];
  bit rdy_port [$];
  bit first_port;

  initial begin
    vecs[0] = '{0, 0, 32'h40, 32'h0,         0, 32'h1234_5678, 32'h0};
    vecs[1] = '{1, 1, 32'h54, 32'hDEAD_BEEF, 1, 32'h1234_5678, 32'h0};
    vecs[2] = '{1, 0, 32'h54, 32'h0,         0, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3] = '{0, 1, 32'h80, 32'hCAFE_F00D, 1, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[4] = '{0, 0, 32'h80, 32'h0,         0, 32'hCAFE_F00D, 32'hDEAD_BEEF};

    reset = 1'b0; pl_all = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst m0_ready", b1.m0_ready, 0);
    chk("rst m1_ready", b1.m1_ready, 0);
    chk("rst mem_we", b1.mem_we, 0);
    chk("rst busy", b1.busy, 0);
    chk("rst grant", b1.grant, 0);
    chk("rst m0_rdata", b1.m0_rdata, 0);
    chk("rst m1_rdata", b1.m1_rdata, 0);
    chk("rst mem_addr", b1.mem_addr, 0);
    chk("rst mem_wdata", b1.mem_wdata, 0);
    chk("rst w0 busy", b0.busy, 0);
    #1 pl_all = 1'b0;
    @(posedge clk); #3 reset = 1'b1;

    // Directed single accesses, WAIT_CYCLES=1.
    for (int i = 0; i < 5; i++) begin
      access1(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              lat, nwe, waddr, wdat, nother, width);
      chk($sformatf("v%0d latency", i), lat, 2);
      chk($sformatf("v%0d ready width", i), width, 1);
      chk($sformatf("v%0d other ready", i), nother, 0);
      chk($sformatf("v%0d mem_we count", i), nwe, vecs[i].exp_nwe);
      if (vecs[i].we) begin
        chk($sformatf("v%0d mem_addr", i), waddr, vecs[i].addr);
        chk($sformatf("v%0d mem_wdata", i), wdat, vecs[i].wdata);
      end
      chk($sformatf("v%0d m0_rdata", i), b1.m0_rdata, vecs[i].exp_rd0);
      chk($sformatf("v%0d m1_rdata", i), b1.m1_rdata, vecs[i].exp_rd1);
      chk($sformatf("v%0d grant hold", i), b1.grant, vecs[i].port);
      chk($sformatf("v%0d busy idle", i), b1.busy, 0);
    end

    // Both ports requesting continuously from reset: alternate 0,1,0,1.
    apply_reset();
    @(posedge clk); #1;
    drive1(0, 1'b1, 1'b0, 32'h40, '0);
    drive1(1, 1'b1, 1'b0, 32'h54, '0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("rr busy c%0d", k), b1.busy, (k % 3) != 0);
      if (b1.m0_ready) begin rdy_cyc.push_back(k); rdy_port.push_back(1'b0); end
      if (b1.m1_ready) begin rdy_cyc.push_back(k); rdy_port.push_back(1'b1); end
    end
    @(posedge clk); #1;
    drive1(0, 1'b0, 1'b0, '0, '0);
    drive1(1, 1'b0, 1'b0, '0, '0);
    chk("rr ready count", rdy_cyc.size(), 4);
    for (int i = 0; i < 4 && i < rdy_cyc.size(); i++) begin
      chk($sformatf("rr grant #%0d", i), rdy_port[i], i % 2);
      chk($sformatf("rr ready cycle #%0d", i), rdy_cyc[i], 3 * i + 2);
    end
    repeat (2) @(posedge clk);

    // Reset in the middle of an m1 write; prio is 1 beforehand.
    access1(0, 1'b0, 32'h40, '0, lat, nwe, waddr, wdat, nother, width);
    chk("pre-abort m0 latency", lat, 2);
    @(posedge clk); #1;
    drive1(1, 1'b1, 1'b1, 32'h60, 32'h55AA_55AA);
    @(negedge clk);
    @(negedge clk);
    chk("abort busy before reset", b1.busy, 1);
    chk("abort mem_we before reset", b1.mem_we, 0);
    #1 reset = 1'b0;
    #1;
    chk("abort busy", b1.busy, 0);
    chk("abort m1_ready", b1.m1_ready, 0);
    chk("abort mem_we", b1.mem_we, 0);
    chk("abort mem_addr", b1.mem_addr, 0);
    chk("abort mem_wdata", b1.mem_wdata, 0);
    chk("abort grant", b1.grant, 0);
    chk("abort m0_rdata", b1.m0_rdata, 0);
    chk("abort m1_rdata", b1.m1_rdata, 0);
    drive1(1, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("abort mem_we held", b1.mem_we, 0);
      chk("abort m1_ready held", b1.m1_ready, 0);
    end
    @(posedge clk); #3 reset = 1'b1;
    chk("abort no write", mem1[24], init_word(24));
    @(posedge clk); #1;
    drive1(0, 1'b1, 1'b0, 32'h40, '0);
    drive1(1, 1'b1, 1'b0, 32'h40, '0);
    kfirst = -1; first_port = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b1.m0_ready || b1.m1_ready) begin
        kfirst = k; first_port = b1.m1_ready;
        @(posedge clk); #1;
        break;
      end
    end
    drive1(0, 1'b0, 1'b0, '0, '0);
    drive1(1, 1'b0, 1'b0, '0, '0);
    chk("post-reset prio port", first_port, 0);
    chk("post-reset prio latency", kfirst, 2);
    @(posedge clk);
    access1(1, 1'b1, 32'h60, 32'h55AA_55AA, lat, nwe, waddr, wdat, nother, width);
    chk("post-reset m1 latency", lat, 2);
    chk("post-reset m1 mem_we", nwe, 1);
    chk("post-reset m1 addr", waddr, 32'h60);
    chk("post-reset m1 grant", b1.grant, 1);

    // m0 drops req and changes operands in the first BUSY cycle.
    @(posedge clk); #1;
    drive1(0, 1'b1, 1'b1, 32'h44, 32'h1111_2222);
    @(negedge clk);
    @(posedge clk); #1;
    drive1(0, 1'b0, 1'b0, 32'h48, 32'h3333_4444);
    nwe = 0; width = 0;
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      if (b1.mem_we) begin nwe++; waddr = b1.mem_addr; wdat = b1.mem_wdata; end
      if (b1.m0_ready) width++;
    end
    chk("drop ready count", width, 1);
    chk("drop mem_we count", nwe, 1);
    chk("drop mem_addr", waddr, 32'h44);
    chk("drop mem_wdata", wdat, 32'h1111_2222);
    chk("drop untouched word", mem1[18], init_word(18));
    drive1(0, 1'b0, 1'b0, '0, '0);

    // WAIT_CYCLES=0: write then read of 0x8, back to back.
    @(posedge clk); #1;
    b0.m0_req = 1; b0.m0_we = 1; b0.m0_addr = 32'h8; b0.m0_wdata = 32'h0BAD_CAFE;
    @(negedge clk);
    chk("w0 ready c0", b0.m0_ready, 0);
    @(negedge clk);
    chk("w0 write ready", b0.m0_ready, 1);
    chk("w0 write mem_we", b0.mem_we, 1);
    chk("w0 write mem_addr", b0.mem_addr, 32'h8);
    chk("w0 write mem_wdata", b0.mem_wdata, 32'h0BAD_CAFE);
    @(posedge clk); #1;
    b0.m0_we = 0;
    @(negedge clk);
    chk("w0 idle gap busy", b0.busy, 0);
    chk("w0 idle gap ready", b0.m0_ready, 0);
    @(negedge clk);
    chk("w0 read ready", b0.m0_ready, 1);
    chk("w0 read mem_we", b0.mem_we, 0);
    @(posedge clk); #1;
    b0.m0_req = 0;
    @(negedge clk);
    chk("w0 read data", b0.m0_rdata, 32'h0BAD_CAFE);
    chk("w0 m1_rdata", b0.m1_rdata, 0);

    // Randomized traffic against a timeline model.
    apply_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    have_acc = 0; rr = 0; lgrant = 0; laddr = '0; lwdata = '0;
    erd[0] = '0; erd[1] = '0;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 0; rdy_prev[p] = 0; new_ops(p);
    end
    for (int cyc = 0; cyc < RandCycles; cyc++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        owned = have_acc && acc.port == p && cyc > acc.start && cyc <= acc.fin;
        if (rdy_prev[p]) begin
          rq[p] = ($urandom_range(3) == 0);
          if (rq[p]) new_ops(p);
        end else if (!rq[p]) begin
          if ($urandom_range(2) == 0) begin rq[p] = 1; new_ops(p); end
        end else if (owned && $urandom_range(3) == 0) begin
          new_ops(p);
        end
      end
      drive1(0, rq[0], rwe[0], ra[0], rd[0]);
      drive1(1, rq[1], rwe[1], ra[1], rd[1]);
      @(negedge clk);
      in_acc   = have_acc && cyc > acc.start && cyc <= acc.fin;
      e_rdy[0] = in_acc && cyc == acc.fin && acc.port == 0;
      e_rdy[1] = in_acc && cyc == acc.fin && acc.port == 1;
      e_we     = in_acc && cyc == acc.fin && acc.we;
      chk("rand busy", b1.busy, in_acc);
      chk("rand grant", b1.grant, lgrant);
      chk("rand m0_ready", b1.m0_ready, e_rdy[0]);
      chk("rand m1_ready", b1.m1_ready, e_rdy[1]);
      chk("rand mem_we", b1.mem_we, e_we);
      chk("rand mem_addr", b1.mem_addr, laddr);
      chk("rand mem_wdata", b1.mem_wdata, lwdata);
      chk("rand m0_rdata", b1.m0_rdata, erd[0]);
      chk("rand m1_rdata", b1.m1_rdata, erd[1]);
      if (in_acc && cyc == acc.fin) begin
        if (acc.we) ref_mem[acc.addr[7:2]] = acc.wdata;
        else        erd[acc.port] = ref_mem[acc.addr[7:2]];
        rr = !acc.port;
        have_acc = 0;
      end
      if (!in_acc && (rq[0] || rq[1])) begin
        winner    = (rq[0] && rq[1]) ? rr : rq[1];
        acc.port  = winner;
        acc.we    = rwe[winner];
        acc.addr  = ra[winner];
        acc.wdata = rd[winner];
        acc.start = cyc;
        acc.fin   = cyc + 1 + W1;
        have_acc  = 1;
        lgrant    = winner;
        laddr     = ra[winner];
        lwdata    = rd[winner];
      end
      rdy_prev = e_rdy;
    end
    idle_inputs();
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
